// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider for the EX stage (RV32M DIV/DIVU/REM/REMU).
// Holds EX via div_ready until the selected quotient or remainder is registered.
module ex_div #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pipe_flush,
    input  logic            div_valid,
    input  logic            div_sign,
    input  logic            div_res_sel,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            div_ack,
    output logic            div_busy,
    output logic            div_ready,
    output logic [XLEN-1:0] div_result
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   rem_q;
    logic [XLEN-1:0]   quo_q;
    logic [XLEN-1:0]   dsr_q;
    logic              sign_q;
    logic              sel_q;
    logic              dnd_neg_q;
    logic              dsr_neg_q;
    logic              ready_q;
    logic [XLEN-1:0]   result_q;

    logic              dnd_neg;
    logic              dsr_neg;
    logic [XLEN-1:0]   dnd_mag;
    logic [XLEN-1:0]   dsr_mag;
    logic              is_zero;
    logic              is_ovf;
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     diff;
    logic              ge;
    logic [XLEN-1:0]   rem_d;
    logic [XLEN-1:0]   quo_d;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;

    always_comb begin
        dnd_neg = div_sign & dividend[XLEN-1];
        dsr_neg = div_sign & divisor[XLEN-1];
        dnd_mag = dnd_neg ? -dividend : dividend;
        dsr_mag = dsr_neg ? -divisor : divisor;
        is_zero = (divisor == '0);
        is_ovf  = div_sign && (dividend == MIN_NEG) && (divisor == ALL_ONES);
    end

    // One restoring step: the borrow out of the (XLEN+1)-bit subtract is the compare result.
    always_comb begin
        rem_shift = {rem_q, quo_q[XLEN-1]};
        diff      = rem_shift - {1'b0, dsr_q};
        ge        = ~diff[XLEN];
        rem_d     = ge ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
        quo_d     = {quo_q[XLEN-2:0], ge};
        quo_fix   = (sign_q && (dnd_neg_q ^ dsr_neg_q)) ? -quo_d : quo_d;
        rem_fix   = (sign_q && dnd_neg_q) ? -rem_d : rem_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dsr_q     <= '0;
            sign_q    <= 1'b0;
            sel_q     <= 1'b0;
            dnd_neg_q <= 1'b0;
            dsr_neg_q <= 1'b0;
            ready_q   <= 1'b0;
            result_q  <= '0;
        end else if (pipe_flush) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (div_valid) begin
                        sign_q    <= div_sign;
                        sel_q     <= div_res_sel;
                        dnd_neg_q <= dnd_neg;
                        dsr_neg_q <= dsr_neg;
                        if (is_zero) begin
                            quo_q    <= ALL_ONES;
                            rem_q    <= dividend;
                            result_q <= div_res_sel ? dividend : ALL_ONES;
                            ready_q  <= 1'b1;
                            state_q  <= DONE;
                        end else if (is_ovf) begin
                            quo_q    <= MIN_NEG;
                            rem_q    <= '0;
                            result_q <= div_res_sel ? '0 : MIN_NEG;
                            ready_q  <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            // The dividend magnitude sits in quo_q and is shifted out as quotient bits shift in.
                            quo_q   <= dnd_mag;
                            dsr_q   <= dsr_mag;
                            rem_q   <= '0;
                            cnt_q   <= CNT_W'(XLEN);
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!div_valid) begin
                        state_q <= IDLE;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            quo_q    <= quo_fix;
                            rem_q    <= rem_fix;
                            result_q <= sel_q ? rem_fix : quo_fix;
                            ready_q  <= 1'b1;
                            state_q  <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (div_ack) begin
                        ready_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign div_busy   = (state_q != IDLE);
    assign div_ready  = ready_q;
    assign div_result = result_q;

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed corner cases plus randomized operands
// compared against a plain-arithmetic RV32M division model.
module tb_ex_div;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rstN = 1'b0;
    logic            pipeFlush = 1'b0;
    logic            divValid = 1'b0;
    logic            divSign = 1'b0;
    logic            divResSel = 1'b0;
    logic [XLEN-1:0] dividend = '0;
    logic [XLEN-1:0] divisor = '0;
    logic            divAck = 1'b0;
    logic            divBusy;
    logic            divReady;
    logic [XLEN-1:0] divResult;

    int testsRun = 0;
    int testsFailed = 0;

    ex_div #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk        (clk),
        .rst_n      (rstN),
        .pipe_flush (pipeFlush),
        .div_valid  (divValid),
        .div_sign   (divSign),
        .div_res_sel(divResSel),
        .dividend   (dividend),
        .divisor    (divisor),
        .div_ack    (divAck),
        .div_busy   (divBusy),
        .div_ready  (divReady),
        .div_result (divResult)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // RISC-V M semantics from plain arithmetic; SV signed / and % truncate toward zero.
    function automatic logic [31:0] refDiv(input logic sgn, input logic sel, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return sel ? r : q;
    endfunction

    function automatic int refLatency(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
            return 1;
        return XLEN + 1;
    endfunction

    task automatic applyStimulus(input logic sgn, input logic sel, input logic [31:0] a, input logic [31:0] b,
                                 input int ackDelay, input string tag);
        logic [31:0] expRes;
        int expLat;
        int cycles;
        expRes = refDiv(sgn, sel, a, b);
        expLat = refLatency(sgn, a, b);
        divSign = sgn;
        divResSel = sel;
        dividend = a;
        divisor = b;
        divValid = 1'b1;
        cycles = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            cycles++;
            if (i == 0) checkOutput({tag, " busy"}, 32'(divBusy), 32'd1);
            if (divReady) break;
        end
        checkOutput({tag, " latency"}, cycles, expLat);
        checkOutput({tag, " result"}, divResult, expRes);
        for (int i = 0; i < ackDelay; i++) begin
            step();
            checkOutput({tag, " hold ready"}, 32'(divReady), 32'd1);
            checkOutput({tag, " hold result"}, divResult, expRes);
        end
        divAck = 1'b1;
        step();
        divAck = 1'b0;
        divValid = 1'b0;
        checkOutput({tag, " ack ready"}, 32'(divReady), 32'd0);
        checkOutput({tag, " ack idle"}, 32'(divBusy), 32'd0);
    endtask

    initial begin
        logic neverReady;
        logic rs;
        logic rsel;
        logic [31:0] ra;
        logic [31:0] rb;
        int mode;

        // Reset state
        rstN = 1'b0;
        step();
        step();
        checkOutput("reset busy", 32'(divBusy), 32'd0);
        checkOutput("reset ready", 32'(divReady), 32'd0);
        checkOutput("reset result", divResult, 32'd0);
        rstN = 1'b1;
        step();

        applyStimulus(1'b0, 1'b0, 32'd100, 32'd7, 0, "u100/7 q");
        applyStimulus(1'b0, 1'b1, 32'd100, 32'd7, 5, "u100/7 r");
        applyStimulus(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 0, "s-7/2 q");
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1, "s-7/2 r");
        applyStimulus(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, 0, "s7/-2 q");
        applyStimulus(1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 0, "s7/-2 r");
        applyStimulus(1'b1, 1'b0, 32'h1234_5678, 32'd0, 2, "sdiv0 q");
        applyStimulus(1'b1, 1'b1, 32'h1234_5678, 32'd0, 0, "sdiv0 r");
        applyStimulus(1'b0, 1'b0, 32'h1234_5678, 32'd0, 0, "udiv0 q");
        applyStimulus(1'b0, 1'b1, 32'h1234_5678, 32'd0, 0, "udiv0 r");
        applyStimulus(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, "sovf q");
        applyStimulus(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "sovf r");
        applyStimulus(1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, "uovf q");
        applyStimulus(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "uovf r");

        // Flush at CALC cycle 10 with div_valid still high
        divSign = 1'b0;
        divResSel = 1'b0;
        dividend = 32'd100;
        divisor = 32'd7;
        divValid = 1'b1;
        repeat (11) step();
        pipeFlush = 1'b1;
        step();
        pipeFlush = 1'b0;
        divValid = 1'b0;
        checkOutput("flush idle", 32'(divBusy), 32'd0);
        checkOutput("flush ready", 32'(divReady), 32'd0);
        neverReady = 1'b1;
        repeat (35) begin
            step();
            if (divReady) neverReady = 1'b0;
        end
        checkOutput("flush no ready", 32'(neverReady), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'd9, 32'd3, 0, "post-flush 9/3");

        // div_valid dropping mid-calculation aborts
        divValid = 1'b1;
        dividend = 32'd50;
        divisor = 32'd5;
        repeat (4) step();
        divValid = 1'b0;
        step();
        checkOutput("abort idle", 32'(divBusy), 32'd0);
        checkOutput("abort ready", 32'(divReady), 32'd0);

        // Reset at CALC cycle 5
        divValid = 1'b1;
        dividend = 32'd1000;
        divisor = 32'd3;
        repeat (6) step();
        rstN = 1'b0;
        divValid = 1'b0;
        step();
        checkOutput("midreset busy", 32'(divBusy), 32'd0);
        checkOutput("midreset ready", 32'(divReady), 32'd0);
        checkOutput("midreset result", divResult, 32'd0);
        rstN = 1'b1;
        step();

        // Randomized operands, biased toward the special cases
        for (int n = 0; n < 24; n++) begin
            rs = 1'($urandom_range(0, 1));
            rsel = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            mode = $urandom_range(0, 7);
            if (mode == 0) rb = 32'd0;
            else if (mode == 1) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end else if (mode == 2) rb = 32'($urandom_range(1, 15));
            else if (mode == 3) rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            applyStimulus(rs, rsel, ra, rb, $urandom_range(0, 3), $sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Iterative radix-2 divider in the EX stage; consumes the decoded divide controls and operands from the ID/EX pipeline register (is_div, div_sign, div_res_sel, rs1, rs2).
- Stalls EX via div_ready until the RV32M DIV/DIVU/REM/REMU result is available, then holds it until EX hands off to MEM.
- Sign, divide-by-zero and overflow handling follow the RISC-V M extension.

Parameters:
- XLEN, 32, operand and result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- pipe_flush  input  1  pipeline flush; aborts any operation.
- div_valid  input  1  EX holds a valid divide instruction (ex valid & ex_is_div_inst).
- div_sign  input  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU).
- div_res_sel  input  1  0 = quotient, 1 = remainder.
- dividend  input  XLEN  rs1 value.
- divisor  input  XLEN  rs2 value.
- div_ack  input  1  EX result accepted by MEM this cycle (ex ready_go & mem allowin).
- div_busy  output  1  state != IDLE.
- div_ready  output  1  result valid; used as EX ready_go for divides.
- div_result  output  XLEN  selected quotient or remainder.

Behaviour:
- Reset (rst_n==0 at clk edge): state IDLE, counter 0, div_busy 0, div_ready 0, div_result 0, internal quotient/remainder/operand registers 0.
- States: IDLE, CALC, DONE. Priority each cycle: reset > pipe_flush > state logic.
- pipe_flush=1 in any state: next state IDLE, div_ready 0, div_result unchanged. A div_valid sampled in the same cycle is ignored.
- IDLE, div_valid=1: latch div_sign, div_res_sel, dividend sign, divisor sign.
  - divisor==0: next DONE; quotient = all ones; remainder = dividend.
  - div_sign=1, dividend=0x80000000, divisor=0xFFFFFFFF: next DONE; quotient = 0x80000000; remainder = 0.
  - Otherwise: latch |dividend| and |divisor| (magnitudes only when div_sign=1, raw values otherwise); clear partial remainder; counter = XLEN; next CALC.
- CALC, one restoring step per cycle:
  - {rem,quo} shifted left 1.
  - If shifted rem >= divisor magnitude: rem -= divisor and quo LSB = 1; else quo LSB = 0.
  - Counter decrements; when it reaches 1 this cycle, next state is DONE.
  - Exactly XLEN cycles in CALC.
  - div_valid dropping to 0 in CALC (no flush): abort to IDLE.
- Entering DONE: apply sign fix-up when div_sign=1.
  - Quotient is negated if the operand signs differ.
  - Remainder is negated if the dividend was negative.
  - Special cases take no fix-up.
  - div_result register loaded with quo or rem per div_res_sel; div_ready=1 from the first DONE cycle.
- DONE: div_ready and div_result held stable while div_ack=0. div_ack=1: next IDLE, div_ready 0 the following cycle. A new div_valid is not accepted in the DONE/ack cycle; it is accepted from IDLE on the next cycle.
- Latency from the div_valid cycle in IDLE to div_ready high:
  - special cases: 1 cycle.
  - normal: XLEN+1 = 33 cycles.
- Arithmetic: internal partial remainder is XLEN+1 bits to hold the compare/subtract carry. Negation is two's complement modulo 2^XLEN.
- div_busy is combinational from state; div_ready and div_result are registered.

Test Plan:
- Unsigned: div_sign=0, sel=0, 100 / 7, div_valid held -> div_ready rises 33 cycles later, div_result=14. Rerun with sel=1 -> 2.
- Signed: div_sign=1, -7 (0xFFFFFFF9) / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Also 7 / -2 -> q=-3, r=1.
- Divide by zero: div_sign=1, 0x12345678 / 0 -> div_ready after 1 cycle; q=0xFFFFFFFF, r=0x12345678. Unsigned case gives the same values.
- Overflow: div_sign=1, 0x80000000 / 0xFFFFFFFF -> 1-cycle latency, q=0x80000000, r=0. Unsigned same operands -> 33 cycles, q=0, r=0x80000000.
- Flush/reset mid-op: pipe_flush at CALC cycle 10 -> IDLE next cycle, div_ready never asserts; a following 9/3 op returns 3. rst_n=0 at CALC cycle 5 -> all outputs 0 next edge.
- Back-pressure: result ready, div_ack held 0 for 5 cycles -> div_ready=1 and div_result constant. div_ack=1 -> div_ready 0 the next cycle; a new op starts from IDLE.
